// File: rtl/keypad_matrix_responder.sv
// 4x4 matrix-keypad emulator: answers active-low row selects with active-low columns.
// Optional contact-bounce bursts on make/break are built when KEYPAD_RESP_BOUNCE_EN is defined.
`timescale 1ns/1ps
module keypad_matrix_responder #(
  parameter int unsigned BOUNCE_CYCLES = 20000,
  parameter int unsigned TOGGLE_DIV    = 256
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       press,
  input  logic       release_cmd,
  input  logic [3:0] r_sel,
  output logic [3:0] col,
  output logic       busy,
  output logic       contact
);

  localparam logic [1:0] ST_IDLE           = 2'd0;
  localparam logic [1:0] ST_PRESS_BOUNCE   = 2'd1;
  localparam logic [1:0] ST_HELD           = 2'd2;
  localparam logic [1:0] ST_RELEASE_BOUNCE = 2'd3;

  if (BOUNCE_CYCLES < 1 || TOGGLE_DIV < 1) begin : g_cfg_check
    $error("keypad_matrix_responder: BOUNCE_CYCLES and TOGGLE_DIV must be >= 1");
  end

  logic [1:0] state;
  logic [3:0] key_q;

`ifdef KEYPAD_RESP_BOUNCE_EN
  localparam int unsigned CW = $clog2(BOUNCE_CYCLES + 1);
  localparam int unsigned DW = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_next;
  logic          div_hit;
  logic          cnt_zero;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign div_hit   = (div == DW'(TOGGLE_DIV - 1));
  assign cnt_zero  = (cnt == '0);

  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      key_q   <= '0;
      contact <= 1'b0;
      cnt     <= '0;
      div     <= '0;
      lfsr    <= 8'hA5;
    end else begin
      case (state)
        ST_IDLE: begin
          contact <= 1'b0;
          if (press) begin
            key_q   <= key;
            state   <= ST_PRESS_BOUNCE;
            contact <= 1'b1;
            cnt     <= CW'(BOUNCE_CYCLES - 1);
            div     <= '0;
          end
        end
        ST_PRESS_BOUNCE, ST_RELEASE_BOUNCE: begin
          // the terminal edge settles the contact; no re-sample competes with it
          if (cnt_zero) begin
            state   <= (state == ST_PRESS_BOUNCE) ? ST_HELD : ST_IDLE;
            contact <= (state == ST_PRESS_BOUNCE);
          end else begin
            cnt <= cnt - CW'(1);
            if (div_hit) begin
              div     <= '0;
              lfsr    <= lfsr_next;
              contact <= lfsr_next[0];
            end else begin
              div <= div + DW'(1);
            end
          end
        end
        ST_HELD: begin
          contact <= 1'b1;
          if (release_cmd) begin
            state   <= ST_RELEASE_BOUNCE;
            contact <= 1'b0;
            cnt     <= CW'(BOUNCE_CYCLES - 1);
            div     <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      key_q   <= '0;
      contact <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          contact <= 1'b0;
          if (press) begin
            key_q   <= key;
            state   <= ST_HELD;
            contact <= 1'b1;
          end
        end
        ST_HELD: begin
          contact <= 1'b1;
          if (release_cmd) begin
            state   <= ST_IDLE;
            contact <= 1'b0;
          end
        end
        ST_PRESS_BOUNCE, ST_RELEASE_BOUNCE: begin
          state   <= ST_IDLE;
          contact <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`endif

  assign busy = (state != ST_IDLE);

  // passive switch: only the latched row can pull the latched column low
  always_comb begin
    col = '1;
    if (contact && !r_sel[key_q[3:2]]) col[key_q[1:0]] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Directed self-checking bench for keypad_matrix_responder (BOUNCE_CYCLES=16, TOGGLE_DIV=2).
`timescale 1ns/1ps
module tb_keypad_matrix_responder;

  logic       int_osc;
  logic       reset;
  logic [3:0] key;
  logic       press;
  logic       release_cmd;
  logic [3:0] r_sel;
  logic [3:0] col;
  logic       busy;
  logic       contact;

  int checks   = 0;
  int failures = 0;

  keypad_matrix_responder #(
    .BOUNCE_CYCLES(16),
    .TOGGLE_DIV   (2)
  ) dut (
    .int_osc    (int_osc),
    .reset      (reset),
    .key        (key),
    .press      (press),
    .release_cmd(release_cmd),
    .r_sel      (r_sel),
    .col        (col),
    .busy       (busy),
    .contact    (contact)
  );

  initial int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  task automatic tick();
    @(posedge int_osc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef KEYPAD_RESP_BOUNCE_EN
  // bit j = contact expected after edge k+j; seed A5 gives 4A,95,2A,54,A9,53,A7 at k+2,k+4,...
  logic [15:0] exp_pb;
`endif

  initial begin
    reset       = 1'b1;
    key         = 4'h0;
    press       = 1'b0;
    release_cmd = 1'b0;
    r_sel       = 4'b1111;
`ifdef KEYPAD_RESP_BOUNCE_EN
    exp_pb      = 16'b1111_1100_0011_0010;
`endif
    tick();
    chk("rst_busy",    {7'd0, busy},    8'h00);
    chk("rst_contact", {7'd0, contact}, 8'h00);
    chk("rst_col",     {4'd0, col},     8'h0F);
    tick();
    reset = 1'b0;

    // reset mid-burst
    key   = 4'b0110;
    r_sel = 4'b1101;
    press = 1'b1;
    tick();
    press = 1'b0;
    chk("mb_entry_busy",    {7'd0, busy},    8'h01);
    chk("mb_entry_contact", {7'd0, contact}, 8'h01);
    chk("mb_entry_col",     {4'd0, col},     8'h0B);
    repeat (5) tick();
    #3 reset = 1'b1;
    #1;
    chk("mb_rst_busy",    {7'd0, busy},    8'h00);
    chk("mb_rst_contact", {7'd0, contact}, 8'h00);
    chk("mb_rst_col",     {4'd0, col},     8'h0F);
    tick();
    reset = 1'b0;
    r_sel = 4'b1111;
    tick();

`ifndef KEYPAD_RESP_BOUNCE_EN
    // release in IDLE is ignored
    release_cmd = 1'b1;
    tick();
    release_cmd = 1'b0;
    chk("idle_rel_busy", {7'd0, busy}, 8'h00);

    // clean column answer for key 1001 (row 2, column 1)
    key   = 4'b1001;
    press = 1'b1;
    tick();
    press = 1'b0;
    chk("held_busy",    {7'd0, busy},    8'h01);
    chk("held_contact", {7'd0, contact}, 8'h01);
    r_sel = 4'b1110; #1 chk("sweep_r0", {4'd0, col}, 8'h0F);
    r_sel = 4'b1101; #1 chk("sweep_r1", {4'd0, col}, 8'h0F);
    r_sel = 4'b1011; #1 chk("sweep_r2", {4'd0, col}, 8'h0D);
    r_sel = 4'b0111; #1 chk("sweep_r3", {4'd0, col}, 8'h0F);

    // press while HELD must not relatch the key
    key   = 4'b0000;
    press = 1'b1;
    tick();
    press = 1'b0;
    r_sel = 4'b1011; #1 chk("held_press_keep", {4'd0, col}, 8'h0D);
    r_sel = 4'b1110; #1 chk("held_press_row0", {4'd0, col}, 8'h0F);

    release_cmd = 1'b1;
    tick();
    release_cmd = 1'b0;
    chk("rel_busy",    {7'd0, busy},    8'h00);
    chk("rel_contact", {7'd0, contact}, 8'h00);
    r_sel = 4'b1011; #1 chk("rel_col", {4'd0, col}, 8'h0F);

    // press and release together in IDLE: press wins
    key         = 4'b0111;
    press       = 1'b1;
    release_cmd = 1'b1;
    tick();
    press       = 1'b0;
    release_cmd = 1'b0;
    chk("both_busy",    {7'd0, busy},    8'h01);
    chk("both_contact", {7'd0, contact}, 8'h01);
`else
    // bounce on make: key 0, row 0 driven
    key   = 4'b0000;
    r_sel = 4'b1110;
    press = 1'b1;
    tick();
    press = 1'b0;
    chk("pb_entry_contact", {7'd0, contact}, 8'h01);
    chk("pb_entry_busy",    {7'd0, busy},    8'h01);
    chk("pb_entry_col",     {4'd0, col},     8'h0E);
    for (int j = 1; j < 16; j++) begin
      tick();
      chk($sformatf("pb_contact_k%0d", j), {7'd0, contact}, {7'd0, exp_pb[j]});
      chk($sformatf("pb_busy_k%0d", j),    {7'd0, busy},    8'h01);
      chk($sformatf("pb_col_k%0d", j),     {4'd0, col},     exp_pb[j] ? 8'h0E : 8'h0F);
    end
    tick();
    chk("held_entry_contact", {7'd0, contact}, 8'h01);
    chk("held_entry_busy",    {7'd0, busy},    8'h01);

    // press while HELD must not relatch the key
    key   = 4'b1111;
    press = 1'b1;
    tick();
    press = 1'b0;
    repeat (3) tick();
    chk("held_contact", {7'd0, contact}, 8'h01);
    chk("held_keep_col", {4'd0, col},    8'h0E);

    // bounce on break, with a press attempted mid-burst
    release_cmd = 1'b1;
    tick();
    release_cmd = 1'b0;
    chk("rb_entry_contact", {7'd0, contact}, 8'h00);
    chk("rb_entry_busy",    {7'd0, busy},    8'h01);
    chk("rb_entry_col",     {4'd0, col},     8'h0F);
    for (int j = 1; j < 16; j++) begin
      key   = 4'b0101;
      press = (j == 3);
      tick();
      press = 1'b0;
      chk($sformatf("rb_busy_m%0d", j), {7'd0, busy}, 8'h01);
    end
    tick();
    chk("rb_done_busy",    {7'd0, busy},    8'h00);
    chk("rb_done_contact", {7'd0, contact}, 8'h00);
    chk("rb_done_col",     {4'd0, col},     8'h0F);
    tick();
    chk("rb_no_queue_busy", {7'd0, busy}, 8'h00);

    // press and release together in IDLE: press wins
    key         = 4'b0111;
    press       = 1'b1;
    release_cmd = 1'b1;
    tick();
    press       = 1'b0;
    release_cmd = 1'b0;
    chk("both_busy",    {7'd0, busy},    8'h01);
    chk("both_contact", {7'd0, contact}, 8'h01);
    repeat (16) tick();
    chk("both_held_contact", {7'd0, contact}, 8'h01);
`endif

    // multi-row drive, key 0111 (row 1, column 3)
    r_sel = 4'b0000; #1 chk("multi_all",  {4'd0, col}, 8'h07);
    r_sel = 4'b1101; #1 chk("multi_row1", {4'd0, col}, 8'h07);
    r_sel = 4'b1011; #1 chk("multi_row2", {4'd0, col}, 8'h0F);
    r_sel = 4'b1111; #1 chk("multi_none", {4'd0, col}, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
